// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and the control-unit decoder.
package cpu_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [5:0] RTYPE   = 6'b000000;
    localparam logic [5:0] SYSCALL = 6'b001100;
    localparam logic [5:0] ADD     = 6'b100000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_register.sv
// Program counter flop with increment/load selection; loaded values are forced word aligned.
module pc_register #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    assign pc_plus4_o = pc_q + ADDR_W'(4);
    assign pc_o       = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i & ALIGN_MASK;
        end else if (inc_i) begin
            pc_d = pc_plus4_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC & ALIGN_MASK;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches instruction words over a req/ready handshake, holds them for the decoder,
// and stops permanently once the decoder reports a halt.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              advance,
    input  logic              halted,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              stopped
);

    fetch_state_t      state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              pc_load, pc_inc;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC[ADDR_W-1:0])
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_pc_i  (redirect_pc),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    inst_d  = imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                // Halt takes priority so the halting instruction's PC stays visible.
                if (halted) begin
                    state_d = HALT;
                end else if (advance) begin
                    state_d = FETCH;
                    pc_load = redirect;
                    pc_inc  = ~redirect;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
        end
    end

    // The request is masked during reset so a reset mid-fetch drops it immediately.
    assign imem_req   = (state_q == FETCH) && !rst;
    assign imem_addr  = pc;
    assign inst       = inst_q;
    assign opcode     = inst_q[31:26];
    assign func       = inst_q[5:0];
    assign inst_valid = (state_q == VALID);
    assign stopped    = (state_q == HALT);

endmodule
